// File: rtl/led_cmd_pkg.sv
// Shared address map, CTRL bit positions and parser state type
// for the SPI-addressed LED controller.
package led_cmd_pkg;

  localparam logic [6:0] ADDR_ID        = 7'h00;
  localparam logic [6:0] ADDR_CTRL      = 7'h01;
  localparam logic [6:0] ADDR_CMDCNT    = 7'h02;
  localparam logic [6:0] ADDR_DUTY_BASE = 7'h10;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_BLINK = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } parser_state_t;

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM channel: duty shadow reloaded at the period wrap plus the
// registered compare that drives a single LED.
module led_pwm_channel #(
  parameter int PWM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PWM_WIDTH-1:0] i_duty,
  input  logic                 i_load,
  input  logic [PWM_WIDTH-1:0] i_pwm_cnt_next,
  input  logic                 i_gate_next,
  output logic                 o_led
);

  logic [PWM_WIDTH-1:0] r_shadow;
  logic [PWM_WIDTH-1:0] w_shadow_next;
  logic                 r_led;

  assign w_shadow_next = i_load ? i_duty : r_shadow;

  // Compare against next-state values so the registered LED lines up with
  // the counter and shadow that become visible on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
      r_led    <= 1'b0;
    end else begin
      r_shadow <= w_shadow_next;
      r_led    <= i_gate_next & (i_pwm_cnt_next < w_shadow_next);
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/led_cmd_regs.sv
// SPI byte-stream transaction parser, register file, shared PWM timebase
// and heartbeat for NUM_LEDS dimmable LED channels.
module led_cmd_regs
  import led_cmd_pkg::*;
#(
  parameter int          NUM_LEDS       = 4,
  parameter int          PWM_WIDTH      = 8,
  parameter int          PRESCALE_WIDTH = 6,
  parameter int          SYS_CNTR_WIDTH = 25,
  parameter logic [7:0]  ID_VALUE       = 8'hA8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          cmd,
  input  logic                cmd_valid,
  input  logic                frame_active,
  output logic [7:0]          response,
  output logic [NUM_LEDS-1:0] led,
  output logic                heartbeat
);

  parser_state_t r_state, w_state_next;
  logic          r_wr;
  logic [6:0]    r_addr;
  logic          r_armed;
  logic [7:0]    r_response;
  logic [1:0]    r_ctrl, w_ctrl_next;
  logic [7:0]    r_cmdcnt;
  logic [PWM_WIDTH-1:0] r_duty [NUM_LEDS];

  logic          w_cmd_accept;
  logic          w_data_byte;
  logic          w_wr_en;
  logic [6:0]    w_rd_addr;
  logic [7:0]    w_rd_data;
  logic [NUM_LEDS-1:0] w_duty_we;

  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [PWM_WIDTH-1:0]      r_pwm_cnt, w_pwm_next;
  logic [SYS_CNTR_WIDTH-1:0] r_syscounter, w_sys_next;
  logic                      w_tick, w_wrap, w_gate_next;

  // Parser state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (!frame_active)
      w_state_next = ST_IDLE;
    else if (cmd_valid && r_state == ST_IDLE && r_armed)
      w_state_next = ST_DATA;
  end

  always_comb begin
    w_cmd_accept = frame_active && cmd_valid && (r_state == ST_IDLE) && r_armed;
    w_data_byte  = frame_active && cmd_valid && (r_state == ST_DATA);
  end

  assign w_wr_en   = w_data_byte && r_wr;
  assign w_rd_addr = w_cmd_accept ? cmd[6:0] : r_addr + 7'd1;

  always_comb begin
    w_rd_data = 8'h00;
    if (w_rd_addr == ADDR_ID)
      w_rd_data = ID_VALUE;
    else if (w_rd_addr == ADDR_CTRL)
      w_rd_data = {6'b0, r_ctrl};
    else if (w_rd_addr == ADDR_CMDCNT)
      w_rd_data = r_cmdcnt;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (w_rd_addr == ADDR_DUTY_BASE + 7'(i))
        w_rd_data = r_duty[i];
    end
  end

  assign w_ctrl_next = (w_wr_en && r_addr == ADDR_CTRL) ?
                       {cmd[CTRL_BLINK], cmd[CTRL_EN]} : r_ctrl;

  // After reset the parser ignores bytes until the current frame has ended.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_armed    <= 1'b0;
      r_response <= ID_VALUE;
      r_ctrl     <= '0;
      r_cmdcnt   <= '0;
    end else begin
      r_ctrl <= w_ctrl_next;
      if (cmd_valid)
        r_cmdcnt <= r_cmdcnt + 8'd1;
      if (!frame_active) begin
        r_armed    <= 1'b1;
        r_response <= ID_VALUE;
      end else if (w_cmd_accept || w_data_byte) begin
        r_response <= w_rd_data;
      end
      if (w_cmd_accept) begin
        r_wr   <= cmd[7];
        r_addr <= cmd[6:0];
      end else if (w_data_byte) begin
        r_addr <= r_addr + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LEDS; i++) r_duty[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++)
        if (w_duty_we[i]) r_duty[i] <= cmd;
    end
  end

  assign w_tick      = &r_prescale;
  assign w_wrap      = w_tick && (&r_pwm_cnt);
  assign w_pwm_next  = w_tick ? r_pwm_cnt + 1'b1 : r_pwm_cnt;
  assign w_sys_next  = r_syscounter + 1'b1;
  assign w_gate_next = w_ctrl_next[CTRL_EN] &
                       (~w_ctrl_next[CTRL_BLINK] | w_sys_next[SYS_CNTR_WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prescale   <= '0;
      r_pwm_cnt    <= '0;
      r_syscounter <= '0;
    end else begin
      r_prescale   <= r_prescale + 1'b1;
      r_pwm_cnt    <= w_pwm_next;
      r_syscounter <= w_sys_next;
    end
  end

  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
    assign w_duty_we[gi] = w_wr_en && (r_addr == ADDR_DUTY_BASE + 7'(gi));

    led_pwm_channel #(
      .PWM_WIDTH(PWM_WIDTH)
    ) u_chan (
      .clk            (clk),
      .rst            (rst),
      .i_duty         (r_duty[gi]),
      .i_load         (w_wrap),
      .i_pwm_cnt_next (w_pwm_next),
      .i_gate_next    (w_gate_next),
      .o_led          (led[gi])
    );
  end

  assign response  = r_response;
  assign heartbeat = r_syscounter[SYS_CNTR_WIDTH-1];

endmodule
